// File: rtl/mux_scan.sv
// -----------------------------------------------------------------------------
// mux_scan
// Registered NUM_CH:1 multiplexer feeding the convolution datapath with feature
// or tap data. In manual mode the channel comes straight from `sel`; in auto
// mode an internal sequencer walks the channels enabled in `mask`, staying
// DWELL cycles on each one and pulsing `wrap` whenever a sweep starts over.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         enable; 0 pauses the block (valid drops, everything else holds)
//   mode       0 = manual select, 1 = auto scan
//   sel        channel index used in manual mode
//   mask       per-channel enable used in auto mode (bit i = channel i)
//   d          packed channel data, channel i = d[i*WIDTH +: WIDTH]
//   out        registered data of channel cur_sel
//   out_valid  out holds valid channel data
//   cur_sel    channel index currently driving out
//   wrap       one-cycle pulse when the auto sweep wraps around
// -----------------------------------------------------------------------------
module mux_scan #(
  parameter  int NUM_CH = 8,
  parameter  int WIDTH  = 8,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       mask,
  input  logic [NUM_CH*WIDTH-1:0] d,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  // A dwell of one cycle still needs a 1-bit counter so the vector is legal.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Every SEL_W-bit index has a slot, so indexing never leaves the array even
  // when NUM_CH is not a power of two.
  localparam int EXT_N = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;

  logic [EXT_N-1:0]    mask_ext_s;
  logic [EXT_N-1:0]    exist_ext_s;
  logic [WIDTH-1:0]    d_arr_s [EXT_N];
  logic                mask_any_s;
  logic [SEL_W-1:0]    low_s;
  logic [SEL_W-1:0]    nxt_s;

  // Lowest-indexed set bit of m (0 when m is empty).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [EXT_N-1:0] m);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = EXT_N - 1; i >= 0; i--) begin
      if (m[i]) res = SEL_W'(i);
    end
    return res;
  endfunction

  // Next set bit strictly above cur, falling back to the lowest set bit.
  // With a single set bit equal to cur this returns cur itself.
  function automatic logic [SEL_W-1:0] next_set(input logic [EXT_N-1:0] m,
                                                input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] res;
    logic             found;
    res   = lowest_set(m);
    found = 1'b0;
    for (int i = 0; i < EXT_N; i++) begin
      if (!found && m[i] && (SEL_W'(i) > cur)) begin
        res   = SEL_W'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Unpack the data bus and widen mask/channel-exists vectors to EXT_N slots.
  always_comb begin
    mask_ext_s  = '0;
    exist_ext_s = '0;
    for (int i = 0; i < EXT_N; i++) begin
      d_arr_s[i] = '0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      mask_ext_s[i]  = mask[i];
      exist_ext_s[i] = 1'b1;
      d_arr_s[i]     = d[i*WIDTH +: WIDTH];
    end
  end

  // Channel-search helpers used by the sequencer.
  always_comb begin
    mask_any_s = |mask_ext_s;
    low_s      = lowest_set(mask_ext_s);
    nxt_s      = next_set(mask_ext_s, sel_q);
  end

  // Next-state and next-output logic for both manual and auto modes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (!en) begin
      // Pause: only the valid flag drops.
      valid_d = 1'b0;
    end else if (!mode) begin
      state_d = ST_IDLE;
      sel_d   = sel;
      cnt_d   = '0;
      if (exist_ext_s[sel]) begin
        out_d   = d_arr_s[sel];
        valid_d = 1'b1;
      end else begin
        out_d   = '0;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ENTRY;
        end
        ST_ENTRY: begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          // Preload the first channel's data so out already matches cur_sel.
          if (mask_any_s) begin
            sel_d = low_s;
            out_d = d_arr_s[low_s];
          end else begin
            sel_d = sel_q;
          end
        end
        ST_SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (mask_any_s) begin
              sel_d  = nxt_s;
              wrap_d = (nxt_s <= sel_q);
            end else begin
              sel_d = sel_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // out is taken from the channel that cur_sel will show, so the two
          // outputs always describe the same channel.
          if (mask_any_s) begin
            out_d   = d_arr_s[sel_d];
            valid_d = mask_ext_s[sel_d];
          end else begin
            out_d   = out_q;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = sel_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;

  localparam int NUM_CH = 8;
  localparam int WIDTH  = 8;
  localparam int DWELL  = 2;
  localparam int SEL_W  = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_ENTRY = 1;
  localparam int PH_SCAN  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH-1:0]       mask;
  logic [NUM_CH*WIDTH-1:0] d;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [SEL_W-1:0]        cur_sel;
  logic                    wrap;

  always #5 clk = ~clk;

  mux_scan #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .mask      (mask),
    .d         (d),
    .out       (out),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .wrap      (wrap)
  );

  // Reference model state
  int         m_phase;
  int         m_cnt;
  int         m_sel;
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan(input int i);
    logic [NUM_CH*WIDTH-1:0] v;
    v = d;
    return v[i*WIDTH +: WIDTH];
  endfunction

  function automatic int low_ch(input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Circular search upward from cur+1; lands on cur itself for a single bit.
  function automatic int next_ch(input int cur, input logic [NUM_CH-1:0] m);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (cur + k) % NUM_CH;
      if (m[c]) return c;
    end
    return cur;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_cnt = 0; m_sel = 0;
    m_out = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    m_wrap = 1'b0;
    if (!en) begin
      m_valid = 1'b0;
    end else if (!mode) begin
      m_phase = PH_IDLE;
      m_sel   = int'(sel);
      m_cnt   = 0;
      if (int'(sel) < NUM_CH) begin
        m_out = chan(int'(sel)); m_valid = 1'b1;
      end else begin
        m_out = 8'h00; m_valid = 1'b0;
      end
    end else if (m_phase == PH_IDLE) begin
      m_phase = PH_ENTRY;
      m_valid = 1'b0;
    end else if (m_phase == PH_ENTRY) begin
      m_phase = PH_SCAN;
      m_cnt   = 0;
      m_valid = 1'b0;
      if (mask != 8'h00) begin
        m_sel = low_ch(mask);
        m_out = chan(m_sel);
      end
    end else begin
      if (m_cnt == DWELL - 1) begin
        m_cnt = 0;
        if (mask != 8'h00) begin
          int n;
          n = next_ch(m_sel, mask);
          m_wrap = (n <= m_sel);
          m_sel  = n;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (mask != 8'h00) begin
        m_out = chan(m_sel); m_valid = mask[m_sel];
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".out"},   32'(out),       32'(m_out));
    check_val({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_val({tag, ".sel"},   32'(cur_sel),   32'(m_sel));
    check_val({tag, ".wrap"},  32'(wrap),      32'(m_wrap));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    check_val("rst_async_out_zero", 32'(out), 32'h0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NUM_CH; i++) d[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
  endtask

  initial begin
    int wraps;
    int first_wrap;
    int gap;
    int seq_exp [8];

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; mask = '0; d = '0;
    set_ramp();
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_edge");
    rst_n = 1'b1;

    // Manual sweep
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = SEL_W'(i);
      step("manual");
      check_val("manual_out_const", 32'(out), 32'(8'h10 + i));
      check_val("manual_valid_const", 32'(out_valid), 32'h1);
    end

    // Asynchronous reset between edges after outputs are non-zero
    do_reset();

    // Auto full scan
    en = 1'b1; mode = 1'b1; mask = 8'hFF;
    step("auto_idle");
    step("auto_entry");
    check_val("entry_valid_low", 32'(out_valid), 32'h0);
    check_val("entry_sel0", 32'(cur_sel), 32'h0);
    wraps = 0; first_wrap = -1; gap = -1;
    for (int k = 1; k <= 40; k++) begin
      step("auto_full");
      if (k == 1) check_val("full_first_out", 32'(out), 32'h10);
      if (wrap) begin
        wraps++;
        if (first_wrap < 0) first_wrap = k;
        else gap = k - first_wrap;
      end
    end
    check_val("full_first_wrap_at", 32'(first_wrap), 32'd16);
    check_val("full_wrap_count", 32'(wraps), 32'd2);
    check_val("full_wrap_gap", 32'(gap), 32'd16);

    // Auto sparse scan, restarted through manual
    mode = 1'b0; sel = '0;
    step("sparse_pre");
    mode = 1'b1; mask = 8'b1010_0100;
    step("sparse_idle");
    step("sparse_entry");
    check_val("sparse_entry_sel", 32'(cur_sel), 32'd2);
    seq_exp = '{2, 5, 5, 7, 7, 2, 2, 5};
    for (int k = 0; k < 8; k++) begin
      step("sparse");
      check_val("sparse_seq", 32'(cur_sel), 32'(seq_exp[k]));
      check_val("sparse_wrap", 32'(wrap), (k == 5) ? 32'h1 : 32'h0);
    end

    // Pause mid-dwell on channel 5
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("pause");
      check_val("pause_valid", 32'(out_valid), 32'h0);
      check_val("pause_sel", 32'(cur_sel), 32'd5);
    end
    en = 1'b1;
    step("resume_a");
    check_val("resume_sel5", 32'(cur_sel), 32'd5);
    check_val("resume_out15", 32'(out), 32'h15);
    step("resume_b");
    check_val("resume_sel7", 32'(cur_sel), 32'd7);
    check_val("resume_out17", 32'(out), 32'h17);

    // Empty mask in auto
    mask = 8'h00;
    for (int k = 0; k < 20; k++) begin
      step("mask0");
      check_val("mask0_valid", 32'(out_valid), 32'h0);
      check_val("mask0_wrap", 32'(wrap), 32'h0);
    end
    mask = 8'h08;
    step("mask08_a");
    step("mask08_b");
    check_val("mask08_sel3", 32'(cur_sel), 32'd3);
    check_val("mask08_wrap", 32'(wrap), 32'h1);
    check_val("mask08_out", 32'(out), 32'h13);

    // Switch back to manual mid-scan
    mode = 1'b0; sel = 3'd6;
    step("to_manual");
    check_val("to_manual_out", 32'(out), 32'h16);

    // Reset mid-scan
    mode = 1'b1; mask = 8'hFF;
    for (int k = 0; k < 5; k++) step("prescan");
    do_reset();
    check_val("rst_mid_valid", 32'(out_valid), 32'h0);

    // Randomised traffic
    for (int k = 0; k < 500; k++) begin
      en   = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 5) != 0);
      sel  = SEL_W'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 7) == 0)
        mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N:1 multiplexer for streaming feature or tap data into the convolution datapath.
- Manual mode: one channel is selected directly by `sel`.
- Auto mode: an internal sequencer scans the channels enabled in `mask`, dwelling DWELL cycles on each, and pulses `wrap` at the end of each sweep.
- Output is registered with a valid flag; generalises the fixed 8:1 combinational mux.

Parameters:
- NUM_CH, 8, number of input channels (>=2).
- WIDTH, 8, bits per channel.
- DWELL, 4, cycles spent on each channel in auto mode (>=1).
- SEL_W, $clog2(NUM_CH), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  enable; 0 pauses the block
- mode  input  1  0 = manual, 1 = auto scan
- sel  input  SEL_W  channel index in manual mode
- mask  input  NUM_CH  channel enable in auto mode; bit i = channel i
- d  input  NUM_CH*WIDTH  packed data; channel i = d[i*WIDTH +: WIDTH]
- out  output  WIDTH  registered selected data
- out_valid  output  1  out holds valid channel data
- cur_sel  output  SEL_W  channel index currently driving out
- wrap  output  1  one-cycle pulse when an auto sweep wraps

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out=0, out_valid=0, cur_sel=0, wrap=0.
  - Dwell counter=0, state=IDLE.
  - Reset mid-scan aborts immediately.
- Register update rules:
  - All outputs are registered on the clk edge; latency is 1 cycle from a d/sel change to out.
  - wrap defaults to 0 every cycle unless stated below.
- en=0:
  - out_valid<=0.
  - out, cur_sel, dwell counter and state hold.
  - No wrap pulse.
- Manual (en=1, mode=0):
  - State goes to IDLE.
  - cur_sel<=sel; dwell counter<=0.
  - If sel<NUM_CH: out<=d[sel], out_valid<=1.
  - If sel>=NUM_CH (non-power-of-2 NUM_CH): out<=0, out_valid<=0.
  - mask is ignored.
- Auto, state machine IDLE -> ENTRY -> SCAN:
  - IDLE: en=1 and mode=1 -> ENTRY.
  - ENTRY (1 cycle):
    - cur_sel<=lowest-indexed set bit of mask, or holds if mask=0.
    - counter<=0, out_valid<=0, then -> SCAN.
  - SCAN, each cycle:
    - out<=d[cur_sel]; out_valid<=mask[cur_sel].
    - Counter increments.
  - Dwell expiry (counter==DWELL-1):
    - counter<=0.
    - cur_sel<=next set mask bit strictly above cur_sel, wrapping to the lowest set bit.
    - If the chosen index is <= the old cur_sel: wrap<=1.
    - Single enabled channel: cur_sel is unchanged and wrap pulses every DWELL cycles.
  - mask=0 in SCAN: out_valid=0, out holds, cur_sel holds, counter still runs, no wrap.
- Mode changes:
  - mode 1->0: manual takes effect on the next edge; state -> IDLE.
  - mode 0->1 while en=1: passes through ENTRY again, so the scan restarts from the lowest enabled channel.
- Mask changes mid-dwell:
  - New mask is used at the next expiry.
  - out_valid tracks mask[cur_sel] immediately (next edge).
- Data changes mid-dwell: out follows d[cur_sel] every cycle (not sampled once per dwell).
- en low then high in SCAN: resumes with the held counter and cur_sel (no ENTRY).

Test Plan (NUM_CH=8, WIDTH=8, DWELL=2, channel i = 8'h10+i):
- Reset with rst_n=0 asserted asynchronously between edges:
  - out=0, out_valid=0, cur_sel=0, wrap=0 immediately, without waiting for a clock edge.
- Manual sweep, en=1, mode=0, sel=0..7 one per cycle:
  - out=8'h10..8'h17 each one cycle later; out_valid=1; cur_sel tracks sel.
- Auto full scan, mask=8'hFF:
  - ENTRY cycle with out_valid=0.
  - Then cur_sel 0,0,1,1,...,7,7,0: out=8'h10,8'h10,8'h11,...
  - wrap=1 for exactly one cycle at the 7->0 advance, then every 16 cycles.
- Auto sparse, mask=8'b1010_0100:
  - cur_sel sequence 2,5,7,2 with 2-cycle dwells.
  - wrap pulses on the 7->2 transition only.
- en dropped for 3 cycles mid-dwell on channel 5:
  - out_valid=0 and cur_sel=5 throughout the pause.
  - After re-enable, 1 remaining dwell cycle on channel 5, then advance to 7.
- Edge cases:
  - mask=0 in auto: out_valid=0, no wrap for 20 cycles.
  - Then mask=8'h08: after 1 cycle, expiry moves cur_sel to 3 and wrap pulses (3 <= old index); out=8'h13.
  - mode->0 with sel=6 mid-scan: out=8'h16 next cycle.
  - Assert rst_n mid-scan: all outputs clear.
